// File: rtl/led_scan_if.sv
// Painter and panel signals of the LED scan sequencer, bundled for the scan block.
// The master side is led_scan; the slave side is the painter plus the HUB75 panel.
interface led_scan_if;
  logic [9:0] frame;
  logic [7:0] subframe;
  logic [5:0] x;
  logic [5:0] y;
  logic [2:0] rgb;
  logic [2:0] rgb_top;
  logic [2:0] rgb_bot;
  logic [4:0] addr;
  logic       sclk;
  logic       latch;
  logic       blank;

  modport master (
    output frame, subframe, x, y,
    input  rgb,
    output rgb_top, rgb_bot, addr, sclk, latch, blank
  );

  modport slave (
    input  frame, subframe, x, y,
    output rgb,
    input  rgb_top, rgb_bot, addr, sclk, latch, blank
  );
endinterface

// File: rtl/led_scan.sv
// HUB75 1/32-scan sequencer: issues painter requests one per clock, realigns the
// painter colour DELAY cycles later, shifts 64 columns per row pair and latches.
module led_scan #(
  parameter int DELAY     = 3,
  parameter int SUBFRAMES = 4,
  parameter int ON_MIN    = 0
) (
  input  logic       clk,
  input  logic       resetn,
  led_scan_if.master bus
);

  localparam int              ON_W       = (ON_MIN > 0) ? $clog2(ON_MIN + 1) : 1;
  localparam logic [ON_W-1:0] ON_CNT_MAX = ON_W'(ON_MIN);
  localparam logic [7:0]      SF_LAST    = 8'(SUBFRAMES - 1);

  typedef enum logic [1:0] {
    ST_SHIFT,
    ST_DRAIN,
    ST_WAIT,
    ST_LATCH
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [6:0]       r_k;
  logic [4:0]       r_row;
  logic [9:0]       r_frame;
  logic [7:0]       r_subframe;
  logic [DELAY-1:0] r_tag_v;
  logic [DELAY-1:0] r_tag_h;
  logic [2:0]       r_top_hold;
  logic [2:0]       r_rgb_top;
  logic [2:0]       r_rgb_bot;
  logic             r_sclk;
  logic             r_rise_pend;
  logic [4:0]       r_addr;
  logic             r_lit;
  logic [ON_W-1:0]  r_on_cnt;

  logic w_req;
  logic w_latch;
  logic w_tag_out_v;
  logic w_tag_out_h;
  logic w_load;
  logic w_hold;
  logic w_drain_done;
  logic w_on_met;
  logic w_blank;

  assign w_tag_out_v  = r_tag_v[DELAY-1];
  assign w_tag_out_h  = r_tag_h[DELAY-1];
  assign w_load       = w_tag_out_v & w_tag_out_h;
  assign w_hold       = w_tag_out_v & ~w_tag_out_h;
  // Done once the pipe is empty and the last column's sclk-high cycle is the current one.
  assign w_drain_done = ~(|r_tag_v) & ~r_rise_pend;
  assign w_on_met     = (r_on_cnt == ON_CNT_MAX);
  assign w_blank      = ~r_lit | w_latch;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_SHIFT;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of process ordering.
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    unique case (r_state)
      ST_SHIFT: if (r_k == 7'd127) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_done)  w_state_next = w_on_met ? ST_LATCH : ST_WAIT;
      ST_WAIT:  if (w_on_met)      w_state_next = ST_LATCH;
      ST_LATCH:                    w_state_next = ST_SHIFT;
      default:                     w_state_next = ST_SHIFT;
    endcase
  end

  always_comb begin
    w_req   = 1'b0;
    w_latch = 1'b0;
    unique case (r_state)
      ST_SHIFT: w_req   = 1'b1;
      ST_LATCH: w_latch = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- requests
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k        <= '0;
      r_row      <= '0;
      r_subframe <= '0;
      r_frame    <= '0;
    end else begin
      if (w_req) r_k <= r_k + 7'd1;
      if (w_latch) begin
        r_row <= r_row + 5'd1;
        if (r_row == 5'd31) begin
          if (r_subframe == SF_LAST) begin
            r_subframe <= '0;
            r_frame    <= r_frame + 10'd1;
          end else begin
            r_subframe <= r_subframe + 8'd1;
          end
        end
      end
    end
  end

  // Tag pipe mirrors the painter latency; clearing it on reset drops in-flight requests.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tag_v <= '0;
      r_tag_h <= '0;
    end else begin
      r_tag_v[0] <= w_req;
      r_tag_h[0] <= r_k[0];
      for (int i = 1; i < DELAY; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_h[i] <= r_tag_h[i-1];
      end
    end
  end

  // ---------------------------------------------------------------- column shift
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_top_hold  <= '0;
      r_rgb_top   <= '0;
      r_rgb_bot   <= '0;
      r_sclk      <= 1'b0;
      r_rise_pend <= 1'b0;
    end else begin
      if (w_hold) r_top_hold <= bus.rgb;
      if (w_load) begin
        r_rgb_top   <= r_top_hold;
        r_rgb_bot   <= bus.rgb;
        r_sclk      <= 1'b0;
        r_rise_pend <= 1'b1;
      end else if (r_rise_pend) begin
        r_sclk      <= 1'b1;
        r_rise_pend <= 1'b0;
      end else if (w_state_next == ST_LATCH) begin
        r_sclk      <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- latch / blank
  // on_cnt starts saturated: before the first latch no row is lit, so nothing to hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_lit    <= 1'b0;
      r_on_cnt <= ON_CNT_MAX;
    end else begin
      if (w_latch) begin
        r_addr   <= r_row;
        r_lit    <= 1'b1;
        r_on_cnt <= '0;
      end else if (!w_blank && !w_on_met) begin
        r_on_cnt <= r_on_cnt + ON_W'(1);
      end
    end
  end

  assign bus.frame    = r_frame;
  assign bus.subframe = r_subframe;
  assign bus.x        = r_k[6:1];
  assign bus.y        = {r_k[0], r_row};
  assign bus.rgb_top  = r_rgb_top;
  assign bus.rgb_bot  = r_rgb_bot;
  assign bus.addr     = r_addr;
  assign bus.sclk     = r_sclk;
  assign bus.latch    = w_latch;
  assign bus.blank    = w_blank;

endmodule

// File: tb/tb_led_scan.sv
// Bench for led_scan: three builds (DELAY 3/1/6, ON_MIN 0/0/200) driven by a random
// painter image, with a row-level reference of columns, latch timing and counters.
module tb_led_scan;

  localparam int D0 = 3;
  localparam int D1 = 1;
  localparam int D2 = 6;
  localparam int ON2 = 200;
  localparam int NSF = 4;

  typedef struct packed {
    logic [9:0] frame;
    logic [7:0] subframe;
    logic [5:0] x;
    logic [5:0] y;
    logic [2:0] top;
    logic [2:0] bot;
    logic [4:0] addr;
    logic       sclk;
    logic       latch;
    logic       blank;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  led_scan_if bus0 ();
  led_scan_if bus1 ();
  led_scan_if bus2 ();

  led_scan #(.DELAY(D0), .SUBFRAMES(NSF), .ON_MIN(0))   u_dut0 (.clk(clk), .resetn(resetn), .bus(bus0));
  led_scan #(.DELAY(D1), .SUBFRAMES(NSF), .ON_MIN(0))   u_dut1 (.clk(clk), .resetn(resetn), .bus(bus1));
  led_scan #(.DELAY(D2), .SUBFRAMES(NSF), .ON_MIN(ON2)) u_dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

  obs_t obs [3];
  assign obs[0] = {bus0.frame, bus0.subframe, bus0.x, bus0.y, bus0.rgb_top, bus0.rgb_bot, bus0.addr, bus0.sclk, bus0.latch, bus0.blank};
  assign obs[1] = {bus1.frame, bus1.subframe, bus1.x, bus1.y, bus1.rgb_top, bus1.rgb_bot, bus1.addr, bus1.sclk, bus1.latch, bus1.blank};
  assign obs[2] = {bus2.frame, bus2.subframe, bus2.x, bus2.y, bus2.rgb_top, bus2.rgb_bot, bus2.addr, bus2.sclk, bus2.latch, bus2.blank};

  // Painter image plus frame/subframe tint, so misaligned counters corrupt colours.
  logic [2:0] tbl [64][64];

  function automatic logic [2:0] paint(input logic [9:0] f, input logic [7:0] s,
                                       input logic [5:0] x, input logic [5:0] y);
    return tbl[y][x] ^ {s[1:0], f[0]};
  endfunction

  // Expected colour for the n-th row shifted since reset, from row count arithmetic.
  function automatic logic [2:0] exp_rgb(input int n, input int y, input int x);
    int sub;
    int frm;
    sub = (n / 32) % NSF;
    frm = (n / (32 * NSF)) % 1024;
    return tbl[y][x] ^ {2'(sub), 1'(frm)};
  endfunction

  logic [2:0] pp0 [D0];
  logic [2:0] pp1 [D1];
  logic [2:0] pp2 [D2];
  always @(posedge clk) begin
    pp0[0] <= paint(bus0.frame, bus0.subframe, bus0.x, bus0.y);
    for (int i = 1; i < D0; i++) pp0[i] <= pp0[i-1];
    pp1[0] <= paint(bus1.frame, bus1.subframe, bus1.x, bus1.y);
    for (int i = 1; i < D1; i++) pp1[i] <= pp1[i-1];
    pp2[0] <= paint(bus2.frame, bus2.subframe, bus2.x, bus2.y);
    for (int i = 1; i < D2; i++) pp2[i] <= pp2[i-1];
  end
  assign bus0.rgb = pp0[D0-1];
  assign bus1.rgb = pp1[D1-1];
  assign bus2.rgb = pp2[D2-1];

  function automatic int dly(input int d);
    return (d == 0) ? D0 : (d == 1) ? D1 : D2;
  endfunction

  function automatic int onmin(input int d);
    return (d == 2) ? ON2 : 0;
  endfunction

  int n_cmp;
  int n_fail;
  int cyc;
  int rows_done [3];
  int ncol [3];
  int next_latch [3];
  int last_latch [3];
  int blank_run [3];
  int early_unblank [3];
  bit post [3];
  bit prev_sclk [3];
  logic [2:0] cap_top [3][64];
  logic [2:0] cap_bot [3][64];

  task automatic check(input string tag, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0d expected %0d (cycle %0d)", tag, d, act, exp, cyc);
    end
  endtask

  task automatic fill_tbl();
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++)
        tbl[y][x] = 3'($urandom);
  endtask

  task automatic init_models();
    for (int d = 0; d < 3; d++) begin
      rows_done[d]     = 0;
      ncol[d]          = 0;
      next_latch[d]    = 130 + dly(d);
      last_latch[d]    = 0;
      blank_run[d]     = 0;
      early_unblank[d] = 0;
      post[d]          = 1'b0;
      prev_sclk[d]     = 1'b0;
    end
  endtask

  task automatic check_reset(input int d);
    obs_t ob;
    ob = obs[d];
    check("rst_frame", d, ob.frame, 0);
    check("rst_subframe", d, ob.subframe, 0);
    check("rst_x", d, ob.x, 0);
    check("rst_y", d, ob.y, 0);
    check("rst_rgb_top", d, ob.top, 0);
    check("rst_rgb_bot", d, ob.bot, 0);
    check("rst_addr", d, ob.addr, 0);
    check("rst_sclk", d, ob.sclk, 0);
    check("rst_latch", d, ob.latch, 0);
    check("rst_blank", d, ob.blank, 1);
  endtask

  task automatic monitor(input int d);
    obs_t ob;
    int   bad;
    int   r;
    ob = obs[d];
    if (post[d]) begin
      check("addr_after_latch", d, ob.addr, (rows_done[d] - 1) % 32);
      check("blank_after_latch", d, ob.blank, 0);
      check("latch_released", d, ob.latch, 0);
      check("row_start_x", d, ob.x, 0);
      check("row_start_y", d, ob.y, rows_done[d] % 32);
      check("subframe", d, ob.subframe, (rows_done[d] / 32) % NSF);
      check("frame", d, ob.frame, (rows_done[d] / (32 * NSF)) % 1024);
      post[d] = 1'b0;
    end
    if (ob.sclk && !prev_sclk[d]) begin
      if (ncol[d] < 64) begin
        cap_top[d][ncol[d]] = ob.top;
        cap_bot[d][ncol[d]] = ob.bot;
      end
      ncol[d]++;
    end
    prev_sclk[d] = ob.sclk;
    if (rows_done[d] == 0 && !ob.blank) early_unblank[d]++;
    if (!ob.blank) blank_run[d]++;
    if (ob.latch) begin
      check("sclk_low_in_latch", d, ob.sclk, 0);
      check("blank_in_latch", d, ob.blank, 1);
      if (onmin(d) == 0) begin
        check("latch_cycle", d, cyc, next_latch[d]);
      end else if (rows_done[d] > 0) begin
        check("row_period_min", d, 32'(cyc - last_latch[d] >= onmin(d) + 1), 1);
        check("on_time_min", d, 32'(blank_run[d] >= onmin(d)), 1);
      end
      if (rows_done[d] == 0) check("blank_before_first_latch", d, early_unblank[d], 0);
      check("columns_per_row", d, ncol[d], 64);
      bad = 0;
      r   = rows_done[d] % 32;
      for (int c = 0; c < 64 && c < ncol[d]; c++) begin
        if (cap_top[d][c] !== exp_rgb(rows_done[d], r, c)) bad++;
        if (cap_bot[d][c] !== exp_rgb(rows_done[d], r + 32, c)) bad++;
      end
      check("column_data", d, bad, 0);
      next_latch[d] += 131 + dly(d);
      last_latch[d]  = cyc;
      rows_done[d]++;
      ncol[d]        = 0;
      blank_run[d]   = 0;
      post[d]        = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 3; d++) monitor(d);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc    = 0;
    init_models();
    for (int d = 0; d < 3; d++) monitor(d);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    init_models();
    fill_tbl();

    // Reset state, then a long run across subframe and frame boundaries.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset(d);
    release_reset();
    while (rows_done[0] < 129 && cyc < 20000) step();
    check("long_run_rows_reached", 0, 32'(rows_done[0] >= 129), 1);
    check("on_min_build_rows_reached", 2, 32'(rows_done[2] >= 2), 1);

    // Fresh start with a new image, then reset in the middle of row 5 (k=70).
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    fill_tbl();
    release_reset();
    while (!(rows_done[0] == 5 && obs[0].x == 6'd35 && obs[0].y == 6'd5) && cyc < 2000) step();
    check("mid_row_point_reached", 0, 32'(cyc < 2000), 1);
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_reset(d);
    fill_tbl();
    repeat (2) @(negedge clk);
    release_reset();
    while ((rows_done[0] < 3 || rows_done[2] < 2) && cyc < 3000) step();
    check("post_reset_rows_reached", 0, 32'(rows_done[0] >= 3 && rows_done[2] >= 2), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
